// File: rtl/dtw_pkg.sv
// Types and helpers shared by the DTW result arbiter and its round-robin sub-block.
package dtw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Wide enough for any legal FIFO word; callers truncate to their own width.
    localparam int PACK_W = 64;

    function automatic int id_width(input int num_cores);
        return $clog2(num_cores);
    endfunction

    // FIFO word layout: {zero pad, core id, score}.
    function automatic logic [PACK_W-1:0] pack_result(input logic [PACK_W-1:0] id,
                                                      input logic [PACK_W-1:0] score,
                                                      input int              score_width);
        return (id << score_width) | score;
    endfunction

endpackage

// File: rtl/dtw_result_arbiter_rr.sv
// Round-robin grant: first requester at or after ptr, wrapping modulo NUM_CORES.
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [ID_WIDTH-1:0]  ptr,
    input  logic                 en,
    output logic [NUM_CORES-1:0] grant,
    output logic [ID_WIDTH-1:0]  grant_idx
);

    logic                found;
    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = ID_WIDTH'((int'(ptr) + k) % NUM_CORES);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dtw_result_arbiter.sv
// Shares one DTW result-FIFO push port between NUM_CORES cores, counting a programmed
// batch of results and pulsing batch_done once the last one has been pushed.
module dtw_result_arbiter
    import dtw_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int SCORE_WIDTH     = 24,
    parameter int FIFO_DIN_WIDTH  = 32,
    parameter int BATCH_CNT_WIDTH = 16
) (
    input  logic                             AXIS_ACLK,
    input  logic                             AXIS_ARESET,
    input  logic                             start,
    input  logic [BATCH_CNT_WIDTH-1:0]       batch_len,
    input  logic [NUM_CORES-1:0]             req_valid,
    input  logic [NUM_CORES*SCORE_WIDTH-1:0] req_score,
    output logic [NUM_CORES-1:0]             req_ready,
    output logic                             dtw_fifo_wren,
    output logic [FIFO_DIN_WIDTH-1:0]        dtw_fifo_din,
    input  logic                             dtw_fifo_full,
    output logic                             busy,
    output logic [BATCH_CNT_WIDTH-1:0]       result_count,
    output logic                             batch_done
);

    localparam int ID_WIDTH = id_width(NUM_CORES);

    state_t                     state, state_nxt;
    logic [BATCH_CNT_WIDTH-1:0] len_q;
    logic                       out_valid;
    logic [FIFO_DIN_WIDTH-1:0]  out_data;
    logic [ID_WIDTH-1:0]        rr_ptr;
    logic [ID_WIDTH-1:0]        grant_idx;
    logic [NUM_CORES-1:0]       grant;
    logic                       count_hit;
    logic                       can_load;
    logic                       transfer;
    logic [SCORE_WIDTH-1:0]     score_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_score
        assign score_arr[g] = req_score[g*SCORE_WIDTH +: SCORE_WIDTH];
    end

    assign dtw_fifo_wren = out_valid & ~dtw_fifo_full;
    assign dtw_fifo_din  = out_data;
    assign busy          = (state != IDLE);
    assign count_hit     = (result_count == len_q);
    // The output slot may be refilled in the same cycle it drains, giving one result per cycle.
    assign can_load      = (state == RUN) && !count_hit && (!out_valid || dtw_fifo_wren);

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .ID_WIDTH  (ID_WIDTH)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (can_load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)      state_nxt = RUN;
            RUN:     if (count_hit)  state_nxt = DRAIN;
            DRAIN:   if (!out_valid) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state      <= IDLE;
            batch_done <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            state      <= state_nxt;
            batch_done <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            len_q        <= '0;
            result_count <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            rr_ptr       <= '0;
        end else begin
            if (state == IDLE && start) begin
                len_q        <= batch_len;
                result_count <= '0;
            end
            if (transfer) begin
                out_data     <= FIFO_DIN_WIDTH'(pack_result(PACK_W'(grant_idx),
                                                            PACK_W'(score_arr[grant_idx]),
                                                            SCORE_WIDTH));
                out_valid    <= 1'b1;
                result_count <= result_count + 1'b1;
                rr_ptr       <= (grant_idx == ID_WIDTH'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;
            end else if (dtw_fifo_wren) begin
                out_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dtw_result_arbiter.sv
// Directed bench for dtw_result_arbiter: a queue-based batch model checked every cycle,
// plus literal expectations for grant order, packed words and batch_done timing.
module tb_dtw_result_arbiter;

    localparam int N  = 4;
    localparam int SW = 24;
    localparam int DW = 32;
    localparam int CW = 16;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic            AXIS_ACLK = 1'b0;
    logic            AXIS_ARESET;
    logic            start;
    logic [CW-1:0]   batch_len;
    logic [N-1:0]    req_valid;
    logic [N*SW-1:0] req_score;
    logic [N-1:0]    req_ready;
    logic            dtw_fifo_wren;
    logic [DW-1:0]   dtw_fifo_din;
    logic            dtw_fifo_full;
    logic            busy;
    logic [CW-1:0]   result_count;
    logic            batch_done;

    dtw_result_arbiter #(
        .NUM_CORES       (N),
        .SCORE_WIDTH     (SW),
        .FIFO_DIN_WIDTH  (DW),
        .BATCH_CNT_WIDTH (CW)
    ) dut (
        .AXIS_ACLK     (AXIS_ACLK),
        .AXIS_ARESET   (AXIS_ARESET),
        .start         (start),
        .batch_len     (batch_len),
        .req_valid     (req_valid),
        .req_score     (req_score),
        .req_ready     (req_ready),
        .dtw_fifo_wren (dtw_fifo_wren),
        .dtw_fifo_din  (dtw_fifo_din),
        .dtw_fifo_full (dtw_fifo_full),
        .busy          (busy),
        .result_count  (result_count),
        .batch_done    (batch_done)
    );

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: batch phase, pending-word queue (output slot), counters.
    int            m_phase = P_IDLE;
    int            m_count = 0;
    int            m_len   = 0;
    int            m_ptr   = 0;
    logic [DW-1:0] m_din   = '0;
    logic [DW-1:0] m_q[$];
    int            m_nxt;
    logic [DW-1:0] m_w;
    int            e_idx;
    logic          e_wren;
    logic          e_can;
    logic [N-1:0]  e_ready;

    int            cyc = 0;
    int            grant_log[$];
    logic [DW-1:0] push_log[$];
    int            wren_cyc[$];
    int            done_cyc[$];

    always @(negedge AXIS_ACLK) begin
        cyc++;
        if (AXIS_ARESET) begin
            m_phase = P_IDLE;
            m_count = 0;
            m_ptr   = 0;
            m_din   = '0;
            m_q.delete();
        end
        e_wren = (m_q.size() != 0) && !dtw_fifo_full;
        e_can  = (m_phase == P_RUN) && (m_count != m_len) && (m_q.size() == 0 || e_wren);
        e_idx  = -1;
        if (e_can)
            for (int k = 0; k < N; k++)
                if (e_idx < 0 && req_valid[(m_ptr + k) % N]) e_idx = (m_ptr + k) % N;
        e_ready = (e_idx >= 0) ? N'(1 << e_idx) : '0;

        check("req_ready",    req_ready,     e_ready);
        check("wren",         dtw_fifo_wren, e_wren);
        check("din",          dtw_fifo_din,  m_din);
        check("busy",         busy,          m_phase != P_IDLE);
        check("result_count", result_count,  CW'(m_count));
        check("batch_done",   batch_done,    m_phase == P_DONE);

        if (dtw_fifo_wren) begin
            push_log.push_back(dtw_fifo_din);
            wren_cyc.push_back(cyc);
        end
        if (batch_done) done_cyc.push_back(cyc);
        for (int k = 0; k < N; k++)
            if (req_ready[k] && req_valid[k]) grant_log.push_back(k);

        if (!AXIS_ARESET) begin
            m_nxt = m_phase;
            case (m_phase)
                P_IDLE:  if (start) begin
                             m_nxt   = P_RUN;
                             m_len   = int'(batch_len);
                             m_count = 0;
                         end
                P_RUN:   if (m_count == m_len) m_nxt = P_DRAIN;
                P_DRAIN: if (m_q.size() == 0)  m_nxt = P_DONE;
                default: m_nxt = P_IDLE;
            endcase
            if (e_wren) void'(m_q.pop_front());
            if (e_idx >= 0) begin
                m_w = (DW'(e_idx) << SW) | DW'(req_score[e_idx*SW +: SW]);
                m_q.push_back(m_w);
                m_din   = m_w;
                m_count = m_count + 1;
                m_ptr   = (e_idx + 1) % N;
            end
            m_phase = m_nxt;
        end
    end

    task automatic tick();
        @(posedge AXIS_ACLK);
        #1;
    endtask

    task automatic pulse_start(input int len);
        batch_len = CW'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!batch_done && i < 60) begin
            tick();
            i++;
        end
        if (!batch_done) check({tag, " batch_done timeout"}, batch_done, 1'b1);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        push_log.delete();
        wren_cyc.delete();
        done_cyc.delete();
    endtask

    initial begin
        AXIS_ARESET   = 1'b1;
        start         = 1'b0;
        batch_len     = '0;
        req_valid     = '0;
        dtw_fifo_full = 1'b0;
        req_score     = {24'h333333, 24'hABCDEF, 24'h222222, 24'h111111};
        repeat (2) tick();
        AXIS_ARESET = 1'b0;
        tick();

        check("reset busy",       busy,          1'b0);
        check("reset count",      result_count,  16'd0);
        check("reset req_ready",  req_ready,     4'b0000);
        check("reset wren",       dtw_fifo_wren, 1'b0);
        check("reset din",        dtw_fifo_din,  32'h0);
        check("reset batch_done", batch_done,    1'b0);

        // 1: reset while a result is held behind a full FIFO.
        req_valid     = 4'b0001;
        dtw_fifo_full = 1'b1;
        pulse_start(4);
        tick();
        check("t1 held din",  dtw_fifo_din,  32'h00111111);
        check("t1 held wren", dtw_fifo_wren, 1'b0);
        #2 AXIS_ARESET = 1'b1;
        #1;
        check("t1 rst busy",      busy,          1'b0);
        check("t1 rst count",     result_count,  16'd0);
        check("t1 rst req_ready", req_ready,     4'b0000);
        check("t1 rst wren",      dtw_fifo_wren, 1'b0);
        check("t1 rst din",       dtw_fifo_din,  32'h0);
        check("t1 rst done",      batch_done,    1'b0);
        tick();
        AXIS_ARESET   = 1'b0;
        dtw_fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1 no wren after release", dtw_fifo_wren, 1'b0);
        end
        req_valid = '0;
        tick();

        // 2: all cores requesting, batch of 8, FIFO always ready.
        clear_logs();
        req_valid = 4'b1111;
        pulse_start(8);
        wait_done("t2");
        tick();
        req_valid = '0;
        check("t2 grant count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check($sformatf("t2 grant[%0d]", i), grant_log[i], i % 4);
        check("t2 push count", wren_cyc.size(), 8);
        if (wren_cyc.size() == 8) begin
            check("t2 back-to-back", wren_cyc[7] - wren_cyc[0], 7);
            if (done_cyc.size() > 0)
                check("t2 done after last push", done_cyc[0] - wren_cyc[7], 2);
        end
        check("t2 result_count", result_count, 16'd8);

        // 3: single result from core 2.
        clear_logs();
        req_valid = 4'b0100;
        pulse_start(1);
        wait_done("t3");
        check("t3 busy in DONE", busy, 1'b1);
        tick();
        req_valid = '0;
        check("t3 push count", push_log.size(), 1);
        if (push_log.size() > 0) check("t3 din", push_log[0], 32'h02ABCDEF);
        check("t3 result_count", result_count, 16'd1);
        check("t3 busy dropped", busy, 1'b0);

        // 4: FIFO full for several cycles while all cores request.
        clear_logs();
        req_valid = 4'b1111;
        pulse_start(4);
        dtw_fifo_full = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4 held din",    dtw_fifo_din,  32'h03333333);
            check("t4 held wren",   dtw_fifo_wren, 1'b0);
            check("t4 no grant",    req_ready,     4'b0000);
            tick();
        end
        dtw_fifo_full = 1'b0;
        #1;
        check("t4 resume wren", dtw_fifo_wren, 1'b1);
        wait_done("t4");
        tick();
        req_valid = '0;
        check("t4 push count", push_log.size(), 4);
        if (push_log.size() == 4) begin
            check("t4 push0", push_log[0], 32'h03333333);
            check("t4 push1", push_log[1], 32'h00111111);
            check("t4 push2", push_log[2], 32'h01222222);
            check("t4 push3", push_log[3], 32'h02ABCDEF);
        end

        // 5a: empty batch.
        clear_logs();
        req_valid = 4'b1111;
        pulse_start(0);
        check("t5 done c1", batch_done, 1'b0);
        tick();
        check("t5 done c2", batch_done, 1'b0);
        tick();
        check("t5 done c3", batch_done, 1'b1);
        tick();
        check("t5 done c4", batch_done, 1'b0);
        check("t5 idle",    busy,       1'b0);
        check("t5 no grants", grant_log.size(), 0);

        // 5b: start during RUN is ignored.
        clear_logs();
        req_valid = '0;
        pulse_start(2);
        tick();
        pulse_start(5);
        req_valid = 4'b0010;
        wait_done("t5b");
        tick();
        req_valid = '0;
        check("t5b result_count", result_count, 16'd2);
        check("t5b grant count", grant_log.size(), 2);

        // 6: cores 1 and 3, pointer left at 2 by the previous batch.
        clear_logs();
        req_valid = 4'b1010;
        pulse_start(3);
        wait_done("t6");
        tick();
        tick();
        check("t6 no 4th grant", req_ready, 4'b0000);
        tick();
        req_valid = '0;
        check("t6 grant count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check("t6 grant0", grant_log[0], 3);
            check("t6 grant1", grant_log[1], 1);
            check("t6 grant2", grant_log[2], 3);
        end
        check("t6 result_count", result_count, 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
